// File: rtl/shift_arbiter_pkg.sv
// Shared widths and FSM state encoding for the shift arbiter and its rotate unit.
package shift_arbiter_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// Combinational rotate-left unit: three log stages rotating by 1, 2 and 4.
module barrel_shifter
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [DATA_W-1:0]  data_o
);

  logic [DATA_W-1:0] rot1, rot2, rot4;

  assign rot1   = shamt_i[0] ? {data_i[DATA_W-2:0], data_i[DATA_W-1]}            : data_i;
  assign rot2   = shamt_i[1] ? {rot1[DATA_W-3:0],   rot1[DATA_W-1:DATA_W-2]}     : rot1;
  assign rot4   = shamt_i[2] ? {rot2[DATA_W-5:0],   rot2[DATA_W-1:DATA_W-4]}     : rot2;
  assign data_o = rot4;

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter feeding one shared rotator into a single output register.
// Optional per-requester saturating grant counters are built when SHIFT_ARB_STATS_EN is defined.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_id
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   gnt_cnt0,
  output logic [CNT_W-1:0]   gnt_cnt1
`endif
);

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_id_q, out_id_d;

  logic               can_accept;
  logic               gnt0, gnt1, gnt_any;
  logic [DATA_W-1:0]  sh_data, sh_res;
  logic [SHAMT_W-1:0] sh_amt;

  // last_q = 1 means requester 1 won most recently, so requester 0 wins the next tie.
  always_comb begin
    can_accept = (state_q == IDLE) || out_ready;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (!rst && can_accept) begin
      if (req0_valid && (!req1_valid || last_q)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign sh_data = gnt1 ? req1_data  : req0_data;
  assign sh_amt  = gnt1 ? req1_shamt : req0_shamt;

  barrel_shifter u_rot (
    .data_i  (sh_data),
    .shamt_i (sh_amt),
    .data_o  (sh_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (gnt_any) state_d = HOLD;
      HOLD: if (out_ready && !gnt_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = (state_q == HOLD);
    req0_ready = gnt0;
    req1_ready = gnt1;
  end

  // Output register only loads on a grant, which keeps it stable while stalled.
  always_comb begin
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    last_d     = last_q;
    if (gnt_any) begin
      out_data_d = sh_res;
      out_id_d   = gnt1;
      last_d     = gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
      out_id_q   <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      last_q     <= last_d;
    end
  end

  assign out_data = out_data_q;
  assign out_id   = out_id_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    cnt0_d = gnt0 ? sat_inc(cnt0_q) : cnt0_q;
    cnt1_d = gnt1 ? sat_inc(cnt1_q) : cnt1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter; SHIFT_ARB_STATS_EN adds the grant-counter scenario.
module tb_shift_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_data;
  logic [2:0] req0_shamt;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_data;
  logic [2:0] req1_shamt;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_id;
`ifdef SHIFT_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  int checks = 0;
  int fails  = 0;
  logic [8:0] exp_q[$];

  shift_arbiter #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rotl(input logic [7:0] d, input logic [2:0] s);
    logic [15:0] t;
    t = {d, d} << s;
    return t[15:8];
  endfunction

  // Scoreboard: every consumed result must match the oldest expected entry.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got id=%0d data=%h, required no result", out_id, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_id, out_data} !== e) begin
          fails++;
          $display("FAIL sb_result: got id=%0d data=%h, required id=%0d data=%h",
                   out_id, out_data, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    req0_data = 8'hFF; req0_shamt = 3'd1; req1_data = 8'hFF; req1_shamt = 3'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %h, required 00", out_data); end
    if (out_id !== 1'b0) begin fails++; $display("FAIL rst_out_id: got %b, required 0", out_id); end
    if (req0_ready !== 1'b0) begin fails++; $display("FAIL rst_req0_ready: got %b, required 0", req0_ready); end
    if (req1_ready !== 1'b0) begin fails++; $display("FAIL rst_req1_ready: got %b, required 0", req1_ready); end
`ifdef SHIFT_ARB_STATS_EN
    checks++;
    if (gnt_cnt0 !== 8'd0 || gnt_cnt1 !== 8'd0) begin
      fails++; $display("FAIL rst_counters: got %0d/%0d, required 0/0", gnt_cnt0, gnt_cnt1);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_data = 8'h62; req0_shamt = 3'd1; out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'hC4});
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL single_ready: got %b, required 10", {req0_ready, req1_ready});
    end
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL single_latency: got out_valid=%b, required 1", out_valid); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL single_to_idle: got out_valid=%b, required 0", out_valid); end
    drain();
  endtask

  task automatic test_tie();
    apply_reset();
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h62; req0_shamt = 3'd3;
    req1_valid = 1'b1; req1_data = 8'h81; req1_shamt = 3'd1;
    exp_q.push_back({1'b0, 8'h13});
    exp_q.push_back({1'b1, 8'h03});
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL tie_first: got %b, required 10", {req0_ready, req1_ready});
    end
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, out_valid} !== 3'b011) begin
      fails++; $display("FAIL tie_second: got %b, required 011", {req0_ready, req1_ready, out_valid});
    end
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL tie_no_bubble: got out_valid=%b, required 1", out_valid); end
    drain();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h62; req0_shamt = 3'd0;
    exp_q.push_back({1'b0, 8'h62});
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin fails++; $display("FAIL stall_accept: got %b, required 1", req0_ready); end
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h81; req1_shamt = 3'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_id, out_data, req0_ready, req1_ready} !== {1'b1, 1'b0, 8'h62, 2'b00}) begin
        fails++;
        $display("FAIL stall_hold: got v=%b id=%b d=%h rdy=%b%b, required v=1 id=0 d=62 rdy=00",
                 out_valid, out_id, out_data, req0_ready, req1_ready);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    exp_q.push_back({1'b1, 8'h03});
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin fails++; $display("FAIL stall_release: got %b, required 1", req1_ready); end
    @(posedge clk);
    #1 req1_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int i0 = 0, i1 = 0, cycles = 0;
    logic r0, r1;
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, rotl(8'h10 + 8'(k), 3'(k))});
      exp_q.push_back({1'b1, rotl(8'hA5 + 8'(k), 3'(7 - k))});
    end
    while ((i0 < 4 || i1 < 4) && cycles < 40) begin
      req0_valid = (i0 < 4); req0_data = 8'h10 + 8'(i0); req0_shamt = 3'(i0);
      req1_valid = (i1 < 4); req1_data = 8'hA5 + 8'(i1); req1_shamt = 3'(7 - i1);
      @(negedge clk);
      r0 = req0_ready; r1 = req1_ready;
      @(posedge clk);
      #1;
      if (r0) i0++;
      if (r1) i1++;
      cycles++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (cycles != 8) begin fails++; $display("FAIL b2b_throughput: got %0d cycles, required 8", cycles); end
    drain();
  endtask

  task automatic test_boundary_shamt();
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hB3; req0_shamt = 3'd7;
    exp_q.push_back({1'b0, 8'hD9});
    @(posedge clk);
    #1 req0_data = 8'h5A; req0_shamt = 3'd0;
    exp_q.push_back({1'b0, 8'h5A});
    @(posedge clk);
    #1 req0_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h55; req0_shamt = 3'd2;
    exp_q.push_back({1'b0, 8'h55});
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_hold: got out_valid=%b, required 1", out_valid); end
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_id, out_data} !== 10'd0) begin
      fails++; $display("FAIL mid_reset: got v=%b id=%b d=%h, required all zero", out_valid, out_id, out_data);
    end
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_discard: got out_valid=%b, required 0", out_valid); end
  endtask

`ifdef SHIFT_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h01; req0_shamt = 3'd1;
    for (int k = 0; k < 300; k++) exp_q.push_back({1'b0, 8'h02});
    repeat (300) @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_cnt0 !== 8'hFF || gnt_cnt1 !== 8'h00) begin
      fails++; $display("FAIL stats_saturate: got %0d/%0d, required 255/0", gnt_cnt0, gnt_cnt1);
    end
    drain();
  endtask
`endif

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_data = '0; req1_shamt = '0;
    test_reset();
    test_single();
    test_tie();
    test_stall();
    test_back_to_back();
    test_boundary_shamt();
    test_reset_mid();
`ifdef SHIFT_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
